// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler.
// State encoding, byte/frame widths, clog2 helper.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT_DONE,
    GAP
  } sched_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshake plus transmitter launch/done bundle.
// master: sources/transmitter side, slave: scheduler side.
interface uart_tx_sched_if #(
  parameter int NREQ = 4
);
  import uart_pkg::*;

  logic [NREQ-1:0]             req_valid;
  logic [UART_DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]             req_ready;
  logic                        tx_start;
  logic [UART_DATA_W-1:0]      tx_data;
  logic                        tx_done;

  modport master (
    output req_valid,
    output req_data,
    output tx_done,
    input  req_ready,
    input  tx_start,
    input  tx_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  tx_done,
    output req_ready,
    output tx_start,
    output tx_data
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports: req (request bits), last (previous grant) -> any_req, winner.
module rr_pick
  import uart_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            any_req,
  output logic [IW-1:0]   winner
);

  logic [IW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest
  // asserted index after last is the one left standing.
  always_comb begin
    any_req = |req;
    winner  = last;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ sources.
// Ports: clk, rst, bus (slave), grant_id, busy, timeout_err.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int  NREQ           = 4,
  parameter int  GAP_CYCLES     = 16,
  parameter int  TIMEOUT_CYCLES = 600000,
  localparam int IW             = clog2(NREQ)
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_sched_if.slave bus,
  output logic [IW-1:0]  grant_id,
  output logic           busy,
  output logic           timeout_err
);

  // A watchdog shorter than one frame can never be met.
  localparam int TMO =
    (TIMEOUT_CYCLES < UART_FRAME_BITS) ?
    UART_FRAME_BITS : TIMEOUT_CYCLES;
  localparam int WW = clog2(TMO + 1);
  localparam int GW = clog2(GAP_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  sched_state_e state_q;
  sched_state_e state_d;

  logic [IW-1:0]          grant_d;
  logic [NREQ-1:0]        ready_q;
  logic [NREQ-1:0]        ready_d;
  logic                   start_q;
  logic                   start_d;
  logic [UART_DATA_W-1:0] data_q;
  logic [UART_DATA_W-1:0] data_d;
  logic                   terr_d;
  logic                   busy_d;
  logic [WW-1:0]          wd_q;
  logic [WW-1:0]          wd_d;
  logic [WW-1:0]          wd_nxt;
  logic [GW-1:0]          gap_q;
  logic [GW-1:0]          gap_d;
  logic                   any_req;
  logic [IW-1:0]          pick;

  logic [UART_DATA_W-1:0] lane [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane[i] =
      bus.req_data[i*UART_DATA_W +: UART_DATA_W];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req     (bus.req_valid),
    .last    (grant_id),
    .any_req (any_req),
    .winner  (pick)
  );

  assign bus.req_ready = ready_q;
  assign bus.tx_start  = start_q;
  assign bus.tx_data   = data_q;

  // Every output is a register, so the next-state logic
  // also produces the next value of each output.
  always_comb begin
    state_d = state_q;
    grant_d = grant_id;
    ready_d = '0;
    start_d = 1'b0;
    data_d  = data_q;
    terr_d  = 1'b0;
    wd_d    = wd_q;
    gap_d   = gap_q;
    wd_nxt  = wd_q + WW'(1);
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = GRANT;
          grant_d       = pick;
          ready_d[pick] = 1'b1;
        end
      end
      GRANT: begin
        data_d  = lane[grant_id];
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_d = wd_nxt;
        // A completing frame beats a simultaneous expiry.
        if (bus.tx_done) begin
          state_d = GAP;
          gap_d   = '0;
        end else if (wd_nxt == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id    <= IW'(NREQ - 1);
      ready_q     <= '0;
      start_q     <= 1'b0;
      data_q      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_id    <= grant_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      data_q      <= data_d;
      busy        <= busy_d;
      timeout_err <= terr_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched.
// Random lanes/data/delays checked against a round-robin reference.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int GAP  = 16;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;
  int ptr   = NREQ - 1;

  logic [7:0] lane_d [NREQ];

  uart_tx_sched_if #(.NREQ(NREQ)) bus ();

  uart_tx_sched #(
    .NREQ           (NREQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL time_limit: bench still running, need finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_data();
    for (int i = 0; i < NREQ; i++)
      bus.req_data[8*i +: 8] = lane_d[i];
  endtask

  // Reference: priority order is last+1, last+2, ... mod NREQ.
  function automatic int rr_ref(input logic [NREQ-1:0] v,
                                input int last);
    int order [$];
    for (int k = 1; k <= NREQ; k++)
      order.push_back((last + k) % NREQ);
    foreach (order[j])
      if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic wait_start(input int lim, output int n);
    n = 0;
    while (bus.tx_start !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    if (bus.tx_start !== 1'b1) n = -1;
  endtask

  // From the tx_start cycle: tx_done after d cycles, then
  // n = cycles from tx_done until busy low (-1 if never).
  task automatic finish_frame(input int d, output int n);
    repeat (d) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) n = -1;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ptr = NREQ - 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      tests++;
      if (bus.req_ready !== 4'b0 || bus.tx_start !== 1'b0 ||
          bus.tx_data !== 8'h00 || grant_id !== 2'd3 ||
          busy !== 1'b0 || timeout_err !== 1'b0) begin
        fails++;
        $display("FAIL reset_state c%0d: rdy=%b st=%b d=%h g=%0d b=%b to=%b need 0,0,00,3,0,0",
                 i, bus.req_ready, bus.tx_start, bus.tx_data,
                 grant_id, busy, timeout_err);
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    int w;
    logic [3:0] seen;
    logic [7:0] exp;
    for (int i = 0; i < NREQ; i++) lane_d[i] = 8'h10 + 8'(i);
    put_data();
    bus.req_valid = '1;
    seen = '0;
    for (int f = 0; f < 5; f++) begin
      w = rr_ref(4'hF, ptr);
      exp = 8'h10 + 8'(f % 4);
      wait_start(100, n);
      tests++;
      if (n < 0) begin
        fails++;
        $display("FAIL rr_start f%0d: no tx_start, need one", f);
      end else begin
        tests++;
        if (bus.tx_data !== exp || grant_id !== 2'(w)) begin
          fails++;
          $display("FAIL rr_order f%0d: data=%h g=%0d need %h g=%0d",
                   f, bus.tx_data, grant_id, exp, w);
        end
        if (f < 4) begin
          tests++;
          if (seen[grant_id] !== 1'b0) begin
            fails++;
            $display("FAIL rr_fair f%0d: lane %0d regranted, seen=%b",
                     f, grant_id, seen);
          end
          seen[grant_id] = 1'b1;
        end
        ptr = w;
        finish_frame(20, n);
        tests++;
        if (n != GAP + 1) begin
          fails++;
          $display("FAIL rr_gap f%0d: busy drop %0d need %0d",
                   f, n, GAP + 1);
        end
      end
    end
    bus.req_valid = '0;
    wait_start(GAP + 4, n);
    finish_frame(5, n);
  endtask

  task automatic test_single();
    int n;
    for (int i = 0; i < NREQ; i++) lane_d[i] = 8'($urandom);
    lane_d[2] = 8'hA5;
    put_data();
    bus.req_valid = 4'b0100;
    tick();
    tests++;
    if (bus.req_ready !== 4'b0100 || bus.tx_start !== 1'b0 ||
        busy !== 1'b1) begin
      fails++;
      $display("FAIL single_ready: rdy=%b st=%b b=%b need 0100,0,1",
               bus.req_ready, bus.tx_start, busy);
    end
    tick();
    tests++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5 ||
        bus.req_ready !== 4'b0 || grant_id !== 2'd2) begin
      fails++;
      $display("FAIL single_start: st=%b d=%h rdy=%b g=%0d need 1,a5,0,2",
               bus.tx_start, bus.tx_data, bus.req_ready, grant_id);
    end
    ptr = 2;
    bus.req_valid = '0;
    tick();
    tests++;
    if (bus.tx_start !== 1'b0) begin
      fails++;
      $display("FAIL single_pulse: st=%b need 0", bus.tx_start);
    end
    finish_frame(19, n);
    tests++;
    if (n != GAP + 1) begin
      fails++;
      $display("FAIL single_busy: drop after %0d need %0d", n, GAP + 1);
    end
    tests++;
    if (bus.tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_hold: d=%h need a5", bus.tx_data);
    end
  endtask

  task automatic test_idle_done();
    int n;
    int l;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (busy !== 1'b0 || bus.req_ready !== 4'b0 ||
          bus.tx_start !== 1'b0 || grant_id !== 2'(ptr) ||
          timeout_err !== 1'b0) begin
        fails++;
        $display("FAIL idle_done c%0d: b=%b rdy=%b st=%b g=%0d to=%b need 0,0,0,%0d,0",
                 i, busy, bus.req_ready, bus.tx_start, grant_id,
                 timeout_err, ptr);
      end
      tick();
    end
    l = $urandom_range(0, NREQ - 1);
    lane_d[l] = 8'($urandom);
    put_data();
    bus.req_valid = 4'(1 << l);
    tick();
    tests++;
    if (bus.req_ready !== 4'(1 << l)) begin
      fails++;
      $display("FAIL idle_then_req: rdy=%b need %b",
               bus.req_ready, 4'(1 << l));
    end
    tick();
    ptr = l;
    bus.req_valid = '0;
    finish_frame(4, n);
  endtask

  task automatic test_watchdog();
    int n;
    int l;
    logic [7:0] exp;
    l = $urandom_range(0, NREQ - 1);
    exp = 8'($urandom);
    lane_d[l] = exp;
    put_data();
    bus.req_valid = 4'(1 << l);
    tick();
    tick();
    tests++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== exp) begin
      fails++;
      $display("FAIL wd_start: st=%b d=%h need 1,%h",
               bus.tx_start, bus.tx_data, exp);
    end
    ptr = l;
    bus.req_valid = '0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    tests++;
    if (n != TMO) begin
      fails++;
      $display("FAIL wd_latency: pulse after %0d need %0d", n, TMO);
    end
    tick();
    tests++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wd_pulse: to=%b b=%b need 0,1",
               timeout_err, busy);
    end
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (n != GAP) begin
      fails++;
      $display("FAIL wd_gap: idle after %0d need %0d", n, GAP);
    end
    l = $urandom_range(0, NREQ - 1);
    exp = 8'($urandom);
    lane_d[l] = exp;
    put_data();
    bus.req_valid = 4'(1 << l);
    tick();
    tick();
    tests++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== exp ||
        grant_id !== 2'(l)) begin
      fails++;
      $display("FAIL wd_recover: st=%b d=%h g=%0d need 1,%h,%0d",
               bus.tx_start, bus.tx_data, grant_id, exp, l);
    end
    ptr = l;
    bus.req_valid = '0;
    finish_frame(7, n);
    tests++;
    if (n != GAP + 1) begin
      fails++;
      $display("FAIL wd_recover_gap: %0d need %0d", n, GAP + 1);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    int l;
    logic saw;
    l = $urandom_range(0, NREQ - 1);
    lane_d[l] = 8'($urandom);
    put_data();
    bus.req_valid = 4'(1 << l);
    tick();
    tick();
    ptr = l;
    bus.req_valid = '0;
    repeat (TMO - 1) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n = 1;
    saw = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (timeout_err === 1'b1) saw = 1'b1;
      tick();
      n++;
    end
    tests++;
    if (saw !== 1'b0 || n != GAP + 1) begin
      fails++;
      $display("FAIL sim_done_wins: to_seen=%b drop=%0d need 0,%0d",
               saw, n, GAP + 1);
    end
    l = $urandom_range(0, NREQ - 1);
    put_data();
    bus.req_valid = 4'(1 << l);
    tick();
    tick();
    ptr = l;
    bus.req_valid = '0;
    repeat (TMO) tick();
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL sim_late_done: to=%b need 1", timeout_err);
    end
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (n != GAP) begin
      fails++;
      $display("FAIL sim_late_gap: idle after %0d need %0d", n, GAP);
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    logic [7:0] exp;
    int w;
    int d;
    int n;
    int l;
    v = '0;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NREQ; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          lane_d[i] = 8'($urandom);
        end
      if (v == 4'b0) begin
        l = $urandom_range(0, NREQ - 1);
        v[l] = 1'b1;
        lane_d[l] = 8'($urandom);
      end
      put_data();
      bus.req_valid = v;
      w = rr_ref(v, ptr);
      exp = lane_d[w];
      tick();
      tests++;
      if (bus.req_ready !== 4'(1 << w) || grant_id !== 2'(w)) begin
        fails++;
        $display("FAIL rand_grant f%0d v=%b: rdy=%b g=%0d need %b,%0d",
                 f, v, bus.req_ready, grant_id, 4'(1 << w), w);
      end
      tick();
      tests++;
      if (bus.tx_start !== 1'b1 || bus.tx_data !== exp) begin
        fails++;
        $display("FAIL rand_start f%0d: st=%b d=%h need 1,%h",
                 f, bus.tx_start, bus.tx_data, exp);
      end
      ptr = w;
      v[w] = 1'b0;
      bus.req_valid = v;
      lane_d[w] = ~exp;
      put_data();
      d = $urandom_range(1, 40);
      finish_frame(d, n);
      tests++;
      if (n != GAP + 1 || bus.tx_data !== exp) begin
        fails++;
        $display("FAIL rand_frame f%0d d=%0d: drop=%0d d=%h need %0d,%h",
                 f, d, n, bus.tx_data, GAP + 1, exp);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    int w;
    for (int i = 0; i < NREQ; i++) lane_d[i] = 8'($urandom);
    put_data();
    bus.req_valid = 4'b0001;
    tick();
    tick();
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (bus.req_ready !== 4'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL mid_ignore c%0d: rdy=%b b=%b need 0,1",
                 i, bus.req_ready, busy);
      end
    end
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || grant_id !== 2'd3 || bus.tx_start !== 1'b0 ||
        bus.tx_data !== 8'h00 || bus.req_ready !== 4'b0 ||
        timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL mid_async: b=%b g=%0d st=%b d=%h rdy=%b to=%b need 0,3,0,00,0,0",
               busy, grant_id, bus.tx_start, bus.tx_data,
               bus.req_ready, timeout_err);
    end
    tick();
    tests++;
    if (bus.tx_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_held: st=%b b=%b need 0,0",
               bus.tx_start, busy);
    end
    rst = 1'b0;
    ptr = NREQ - 1;
    w = rr_ref(4'b1010, ptr);
    tick();
    tests++;
    if (bus.req_ready !== 4'(1 << w) || grant_id !== 2'(w)) begin
      fails++;
      $display("FAIL mid_first: rdy=%b g=%0d need %b,%0d",
               bus.req_ready, grant_id, 4'(1 << w), w);
    end
    tick();
    tests++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== lane_d[w]) begin
      fails++;
      $display("FAIL mid_first_data: st=%b d=%h need 1,%h",
               bus.tx_start, bus.tx_data, lane_d[w]);
    end
    ptr = w;
    bus.req_valid = 4'b1010 & ~4'(1 << w);
    finish_frame(3, n);
    w = rr_ref(bus.req_valid, ptr);
    tick();
    tick();
    tests++;
    if (bus.tx_start !== 1'b1 || grant_id !== 2'(w) ||
        bus.tx_data !== lane_d[w]) begin
      fails++;
      $display("FAIL mid_second: st=%b g=%0d d=%h need 1,%0d,%h",
               bus.tx_start, grant_id, bus.tx_data, w, lane_d[w]);
    end
    ptr = w;
    bus.req_valid = '0;
    finish_frame(3, n);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_idle_done();
    test_watchdog();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
